video_eth_tx_sched: RTL

//  Packet scheduler in front of the video UDP transmitter. Splits the pixel stream into
//  UDP packets: one frame-header packet per frame, then one line packet per video line.

---
 rtl/video_eth_tx_sched.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/video_eth_tx_sched.sv
// Packet scheduler for the video UDP transmitter: one header packet per frame, one packet per line,
// inter-packet gap and stalled-transmitter timeout recovery.
module video_eth_tx_sched #(
    parameter int unsigned LINE_WORDS = 320,
    parameter int unsigned H_PIX      = 640,
    parameter int unsigned V_PIX      = 480,
    parameter int unsigned IPG_CYCLES = 12,
    parameter int unsigned TIMEOUT    = 65535,
    parameter int unsigned CNT_W      = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             frame_start,
    input  logic [CNT_W-1:0] fifo_rd_cnt,
    input  logic [31:0]      fifo_dout,
    output logic             fifo_rd_en,
    input  logic             tx_req,
    input  logic             tx_done,
    output logic             tx_start_en,
    output logic [15:0]      tx_byte_num,
    output logic [31:0]      tx_data,
    output logic             busy,
    output logic [15:0]      line_idx,
    output logic [15:0]      frame_cnt,
    output logic             err_timeout
);

    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned IPG_W  = $clog2(IPG_CYCLES + 1);
    localparam int unsigned WIDX_W = $clog2(LINE_WORDS + 2);

    typedef enum logic [1:0] {S_IDLE, S_START, S_SEND, S_GAP} state_t;

    state_t             state_q, state_d;
    logic               is_hdr_q, is_hdr_d;
    logic               hdr_pend_q, hdr_pend_d;
    logic [WIDX_W-1:0]  widx_q, widx_d;
    logic [WIDX_W-1:0]  pkt_words;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [IPG_W-1:0]   gap_q, gap_d;
    logic               start_q, start_d;
    logic [15:0]        byte_num_q, byte_num_d;
    logic [31:0]        data_q, data_d;
    logic               sel_fifo_q, sel_fifo_d;
    logic               busy_q, busy_d;
    logic [15:0]        line_idx_q, line_idx_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            is_hdr_q    <= 1'b0;
            hdr_pend_q  <= 1'b0;
            widx_q      <= '0;
            tmo_q       <= '0;
            gap_q       <= '0;
            start_q     <= 1'b0;
            byte_num_q  <= '0;
            data_q      <= '0;
            sel_fifo_q  <= 1'b0;
            busy_q      <= 1'b0;
            line_idx_q  <= '0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_hdr_q    <= is_hdr_d;
            hdr_pend_q  <= hdr_pend_d;
            widx_q      <= widx_d;
            tmo_q       <= tmo_d;
            gap_q       <= gap_d;
            start_q     <= start_d;
            byte_num_q  <= byte_num_d;
            data_q      <= data_d;
            sel_fifo_q  <= sel_fifo_d;
            busy_q      <= busy_d;
            line_idx_q  <= line_idx_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

    assign pkt_words = is_hdr_q ? WIDX_W'(2) : WIDX_W'(LINE_WORDS + 1);

    always_comb begin
        state_d     = state_q;
        is_hdr_d    = is_hdr_q;
        hdr_pend_d  = hdr_pend_q | frame_start;
        widx_d      = widx_q;
        tmo_d       = tmo_q;
        gap_d       = gap_q;
        start_d     = 1'b0;
        byte_num_d  = byte_num_q;
        data_d      = data_q;
        sel_fifo_d  = sel_fifo_q;
        line_idx_d  = line_idx_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;
        fifo_rd_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable && hdr_pend_q) begin
                    state_d    = S_START;
                    is_hdr_d   = 1'b1;
                    start_d    = 1'b1;
                    byte_num_d = 16'd8;
                end else if (enable && (32'(fifo_rd_cnt) >= LINE_WORDS)) begin
                    state_d    = S_START;
                    is_hdr_d   = 1'b0;
                    start_d    = 1'b1;
                    byte_num_d = 16'(4 + 4 * LINE_WORDS);
                end
            end
            S_START: begin
                state_d = S_SEND;
                widx_d  = '0;
                tmo_d   = TMO_W'(1);
                // A frame_start arriving now belongs to a newer frame and keeps the header pending
                if (is_hdr_q) begin
                    hdr_pend_d  = frame_start;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    line_idx_d  = '0;
                end
            end
            S_SEND: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (tx_req && (widx_q < pkt_words)) begin
                    widx_d = widx_q + WIDX_W'(1);
                    if (widx_q == '0) begin
                        sel_fifo_d = 1'b0;
                        data_d     = is_hdr_q ? {16'hAA55, frame_cnt_q} : {16'h5A5A, line_idx_q};
                    end else if (is_hdr_q) begin
                        sel_fifo_d = 1'b0;
                        data_d     = {16'(H_PIX), 16'(V_PIX)};
                    end else begin
                        fifo_rd_en = 1'b1;
                        sel_fifo_d = 1'b1;
                    end
                end
                if (tx_done) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                    if (!is_hdr_q) begin
                        line_idx_d = (line_idx_q == 16'(V_PIX - 1)) ? 16'd0 : line_idx_q + 16'd1;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT)) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                    err_d   = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == IPG_W'(IPG_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + IPG_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign tx_start_en = start_q;
    assign tx_byte_num = byte_num_q;
    assign tx_data     = sel_fifo_q ? fifo_dout : data_q;
    assign busy        = busy_q;
    assign line_idx    = line_idx_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_timeout = err_q;

endmodule
